// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq -- iterative 16-by-8 integer divider, radix-2 shift-subtract,
// one quotient bit per clock. Handles unsigned and signed operands. Signed
// results truncate toward zero, and the remainder takes the dividend's sign.
// Latency is fixed at 17 edges from the start sample to the result update.
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start_i  in   launch request, sampled when not computing
//   sgn_i    in   1 = signed two's-complement operands
//   dvd_i    in   16-bit dividend
//   dvs_i    in   8-bit divisor
//   busy_o   out  division in progress
//   done_o   out  one-cycle pulse when results are valid
//   quot_o   out  16-bit quotient (held until the next result)
//   rem_o    out  8-bit remainder (held until the next result)
//   dz_o     out  divide-by-zero flag for the last result
//   of_o     out  signed-overflow flag for the last result
// ---------------------------------------------------------------------------
module div_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        sgn_i,
    input  logic [15:0] dvd_i,
    input  logic [7:0]  dvs_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] quot_o,
    output logic [7:0]  rem_o,
    output logic        dz_o,
    output logic        of_o
);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t      state_q;
    logic [15:0] dq_q;      // dividend magnitude, quotient bits shift in at LSB
    logic [8:0]  prem_q;    // partial remainder
    logic [7:0]  dvs_q;     // divisor magnitude
    logic [3:0]  cnt_q;
    logic        negq_q;    // quotient must be negated
    logic        negr_q;    // remainder must be negated
    logic        zero_q;    // divisor was zero
    logic        ovf_q;     // 0x8000 / -1 in signed mode

    // Launch-time operand conditioning
    logic        dvd_neg, dvs_neg;
    logic [15:0] dvd_mag;
    logic [7:0]  dvs_mag;

    // One iteration of the shift-subtract loop
    logic [8:0]  sh;
    logic        ge;
    logic [8:0]  prem_d;
    logic [15:0] dq_d;

    // Sign fix-up of the final magnitudes
    logic [15:0] quot_d;
    logic [7:0]  rem_d;

    always_comb begin
        dvd_neg = sgn_i & dvd_i[15];
        dvs_neg = sgn_i & dvs_i[7];
        // 16 bits suffice: |-32768| = 0x8000 is representable unsigned
        dvd_mag = dvd_neg ? (~dvd_i + 16'd1) : dvd_i;
        dvs_mag = dvs_neg ? (~dvs_i + 8'd1)  : dvs_i;

        // prem stays below the divisor (<= 254), so its low 8 bits carry it
        sh     = {prem_q[7:0], dq_q[15]};
        ge     = (sh >= {1'b0, dvs_q});
        prem_d = ge ? (sh - {1'b0, dvs_q}) : sh;
        dq_d   = {dq_q[14:0], ge};

        quot_d = negq_q ? (~dq_q + 16'd1) : dq_q;
        rem_d  = negr_q ? (~prem_q[7:0] + 8'd1) : prem_q[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dq_q    <= '0;
            prem_q  <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            quot_o  <= '0;
            rem_o   <= '0;
            dz_o    <= 1'b0;
            of_o    <= 1'b0;
        end else begin
            case (state_q)
                // The edge that ends the done cycle is the first point where a
                // new request can be taken, giving one division per 18 cycles.
                IDLE, DONE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        negq_q  <= dvd_neg ^ dvs_neg;
                        negr_q  <= dvd_neg;
                        zero_q  <= (dvs_i == 8'h00);
                        ovf_q   <= sgn_i & (dvd_i == 16'h8000) & (dvs_i == 8'hFF);
                        dq_q    <= dvd_mag;
                        dvs_q   <= dvs_mag;
                        prem_q  <= '0;
                        cnt_q   <= 4'd15;
                        busy_o  <= 1'b1;
                        state_q <= ITER;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ITER: begin
                    prem_q <= prem_d;
                    dq_q   <= dq_d;
                    if (cnt_q == 4'd0) state_q <= FIX;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                FIX: begin
                    // Overflow needs no override: |0x8000|/1 negated is 0x8000, rem 0
                    if (zero_q) begin
                        quot_o <= 16'hFFFF;
                        rem_o  <= 8'h00;
                    end else begin
                        quot_o <= quot_d;
                        rem_o  <= rem_d;
                    end
                    dz_o    <= zero_q;
                    of_o    <= ovf_q & ~zero_q;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b1;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sgn;
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic        busy, done, dz, of;
    logic [15:0] quot;
    logic [7:0]  rem;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(start),
        .sgn_i  (sgn),
        .dvd_i  (dvd),
        .dvs_i  (dvs),
        .busy_o (busy),
        .done_o (done),
        .quot_o (quot),
        .rem_o  (rem),
        .dz_o   (dz),
        .of_o   (of)
    );

    // Reference: plain integer division with the documented special cases
    function automatic void model(input logic s, input logic [15:0] a, input logic [7:0] b,
                                  output logic [15:0] q, output logic [7:0] r,
                                  output logic z, output logic o);
        int sa, sb;
        q = 16'hFFFF; r = 8'h00; z = 1'b0; o = 1'b0;
        if (b == 8'h00) begin
            z = 1'b1;
        end else if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            if (sa == -32768 && sb == -1) begin
                q = 16'h8000; o = 1'b1;
            end else begin
                q = 16'(sa / sb);
                r = 8'(sa % sb);
            end
        end else begin
            q = a / {8'h00, b};
            r = 8'(a % {8'h00, b});
        end
    endfunction

    // Present one request for exactly one sampling edge, then scramble the
    // operand inputs so any late sampling shows up.
    task automatic launch(input logic s, input logic [15:0] a, input logic [7:0] b);
        @(negedge clk);
        start = 1'b1; sgn = s; dvd = a; dvs = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        sgn = 1'($urandom); dvd = 16'($urandom); dvs = 8'($urandom);
    endtask

    // Edges after the start sample until done is seen (-1 on timeout);
    // busy_ok reports busy high before done and never together with done.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat = -1; busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (busy) busy_ok = 1'b0;
                lat = k;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; sgn = 1'b0; dvd = '0; dvs = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, quot, rem, dz, of} !== 28'h0) begin
            failures++;
            $display("FAIL reset_values: got busy=%b done=%b quot=%h rem=%h dz=%b of=%b, want all 0",
                     busy, done, quot, rem, dz, of);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic        ts [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [15:0] ta [8] = '{16'd1000, 16'hFC18, 16'h03E8, 16'hFFFF, 16'h8000, 16'h8000, 16'h1234, 16'h1234};
        logic [7:0]  tb [8] = '{8'd7, 8'h07, 8'hF9, 8'hFF, 8'hFF, 8'h80, 8'h00, 8'h00};
        logic [15:0] eq [8] = '{16'h008E, 16'hFF72, 16'hFF72, 16'h0101, 16'h8000, 16'h0100, 16'hFFFF, 16'hFFFF};
        logic [7:0]  er [8] = '{8'h06, 8'hFA, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        logic        ez [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        eo [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        int lat; bit bok;
        for (int i = 0; i < 8; i++) begin
            launch(ts[i], ta[i], tb[i]);
            wait_done(lat, bok);
            checks++;
            if (lat !== 17 || !bok) begin
                failures++;
                $display("FAIL directed_latency[%0d]: got done after %0d edges busy_ok=%b, want 17 and 1", i, lat, bok);
            end
            checks++;
            if (quot !== eq[i] || rem !== er[i] || dz !== ez[i] || of !== eo[i]) begin
                failures++;
                $display("FAIL directed_result[%0d]: got q=%h r=%h dz=%b of=%b, want q=%h r=%h dz=%b of=%b",
                         i, quot, rem, dz, of, eq[i], er[i], ez[i], eo[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL directed_done_width[%0d]: got done=%b busy=%b after pulse, want 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_random;
        logic s; logic [15:0] a; logic [7:0] b;
        logic [15:0] q; logic [7:0] r; logic z, o;
        int lat; bit bok;
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom);
            a = 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            if (i % 10 == 3) begin s = 1'b1; a = 16'h8000; b = 8'hFF; end
            model(s, a, b, q, r, z, o);
            launch(s, a, b);
            wait_done(lat, bok);
            checks++;
            if (lat !== 17 || !bok || quot !== q || rem !== r || dz !== z || of !== o) begin
                failures++;
                $display("FAIL random[%0d] s=%b %h/%h: got lat=%0d bok=%b q=%h r=%h dz=%b of=%b, want lat=17 bok=1 q=%h r=%h dz=%b of=%b",
                         i, s, a, b, lat, bok, quot, rem, dz, of, q, r, z, o);
            end
        end
    endtask

    task automatic test_back_to_back;
        int ndone = 0;
        bit idle = 1'b0;
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; dvd = 16'd1000; dvs = 8'd7;
        @(posedge clk);               // first accepted sample
        for (int k = 1; k <= 54; k++) begin
            @(posedge clk); #1;
            checks++;
            if (busy && done) begin
                failures++;
                $display("FAIL b2b_overlap: busy and done both high at edge %0d, want exclusive", k);
            end
            if (done) begin
                checks++;
                if (k !== 17 + 18 * ndone || quot !== 16'h008E || rem !== 8'h06) begin
                    failures++;
                    $display("FAIL b2b_pulse: got done at edge %0d q=%h r=%h, want edge %0d q=008e r=06",
                             k, quot, rem, 17 + 18 * ndone);
                end
                ndone++;
            end
        end
        start = 1'b0;
        checks++;
        if (ndone !== 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d done pulses in 54 edges, want 3", ndone);
        end
        for (int k = 0; k < 40 && !idle; k++) begin
            @(posedge clk); #1;
            if (!busy && !done) idle = 1'b1;
        end
        checks++;
        if (!idle) begin
            failures++;
            $display("FAIL b2b_drain: got busy=%b done=%b after 40 edges, want idle", busy, done);
        end
    endtask

    task automatic test_ignore_busy;
        logic [15:0] q; logic [7:0] r; logic z, o;
        int lat = -1; bit extra = 1'b0;
        model(1'b1, 16'hFC18, 8'h07, q, r, z, o);
        launch(1'b1, 16'hFC18, 8'h07);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
            // Glitch a competing request on some cycles of the busy window
            start = (k % 3 == 0); sgn = 1'b0; dvd = 16'd50000; dvs = 8'd3;
        end
        start = 1'b0;
        checks++;
        if (lat !== 17 || quot !== q || rem !== r || dz !== z || of !== o) begin
            failures++;
            $display("FAIL ignore_busy: got lat=%0d q=%h r=%h dz=%b of=%b, want lat=17 q=%h r=%h dz=%b of=%b",
                     lat, quot, rem, dz, of, q, r, z, o);
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done || busy) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            failures++;
            $display("FAIL ignore_busy_queue: got activity after the accepted division, want none");
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] q; logic [7:0] r; logic z, o;
        int lat; bit bok; bit saw_done = 1'b0;
        launch(1'b0, 16'd60000, 8'd13);
        repeat (7) @(posedge clk);    // now in cycle 8 of the division
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, quot, rem, dz, of} !== 28'h0) begin
            failures++;
            $display("FAIL reset_mid_values: got busy=%b done=%b quot=%h rem=%h dz=%b of=%b, want all 0",
                     busy, done, quot, rem, dz, of);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL reset_mid_no_done: got activity after abort, want none");
        end
        model(1'b1, 16'h7FFF, 8'h81, q, r, z, o);
        launch(1'b1, 16'h7FFF, 8'h81);
        wait_done(lat, bok);
        checks++;
        if (lat !== 17 || !bok || quot !== q || rem !== r || dz !== z || of !== o) begin
            failures++;
            $display("FAIL reset_mid_restart: got lat=%0d q=%h r=%h dz=%b of=%b, want lat=17 q=%h r=%h dz=%b of=%b",
                     lat, quot, rem, dz, of, q, r, z, o);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_ignore_busy;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
